// File: rtl/serial_adder_if.sv
// Start/busy/done handshake bundle for the bit-serial adder.
// When SERIAL_ADDER_OVF_EN is defined the bundle also carries the Ovf flag.
interface serial_adder_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] S;
   logic             Co;
`ifdef SERIAL_ADDER_OVF_EN
   logic             Ovf;

   modport master (output start, A, B, Cin, input busy, done, S, Co, Ovf);
   modport slave  (input start, A, B, Cin, output busy, done, S, Co, Ovf);
`else
   modport master (output start, A, B, Cin, input busy, done, S, Co);
   modport slave  (input start, A, B, Cin, output busy, done, S, Co);
`endif
endinterface

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: S = A + B + Cin, one bit per clock, LSB first.
// Define SERIAL_ADDER_OVF_EN to add the two's-complement overflow output Ovf.
module serial_adder #(
   parameter int WIDTH = 4
) (
   input logic           clk,
   input logic           rst,
   serial_adder_if.slave bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] a_reg, b_reg, acc_reg, s_reg;
   logic             c_reg, co_reg;
   logic [CW-1:0]    cnt_reg;
   logic             busy_next, done_next;
   logic             sum_bit, carry_next, last_bit, accept;

   assign sum_bit    = a_reg[0] ^ b_reg[0] ^ c_reg;
   assign carry_next = (a_reg[0] & b_reg[0]) | (a_reg[0] & c_reg) | (b_reg[0] & c_reg);
   assign last_bit   = (cnt_reg == CW'(WIDTH - 1));
   // DONE accepts a new start as well, giving back-to-back operation.
   assign accept     = bus.start && (state_reg != RUN);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      busy_next  = 1'b0;
      done_next  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.start) state_next = RUN;
         end
         RUN: begin
            busy_next = 1'b1;
            if (last_bit) state_next = DONE;
         end
         DONE: begin
            done_next  = 1'b1;
            state_next = bus.start ? RUN : IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_reg   <= '0;
         b_reg   <= '0;
         acc_reg <= '0;
         s_reg   <= '0;
         c_reg   <= 1'b0;
         co_reg  <= 1'b0;
         cnt_reg <= '0;
      end else if (accept) begin
         a_reg   <= bus.A;
         b_reg   <= bus.B;
         c_reg   <= bus.Cin;
         cnt_reg <= '0;
      end else if (state_reg == RUN) begin
         a_reg   <= a_reg >> 1;
         b_reg   <= b_reg >> 1;
         c_reg   <= carry_next;
         acc_reg <= {sum_bit, acc_reg[WIDTH-1:1]};
         if (last_bit) begin
            s_reg  <= {sum_bit, acc_reg[WIDTH-1:1]};
            co_reg <= carry_next;
         end else begin
            cnt_reg <= cnt_reg + CW'(1);
         end
      end
   end

`ifdef SERIAL_ADDER_OVF_EN
   logic ovf_reg;

   // On the last bit c_reg is the carry into the MSB.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_reg <= 1'b0;
      end else if (!accept && state_reg == RUN && last_bit) begin
         ovf_reg <= c_reg ^ carry_next;
      end
   end

   assign bus.Ovf = ovf_reg;
`endif

   assign bus.busy = busy_next;
   assign bus.done = done_next;
   assign bus.S    = s_reg;
   assign bus.Co   = co_reg;

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial ripple adder: the add-direction counterpart of the team's combinational subtractor datapath.
- Computes S = A + B + Cin one bit per clock, LSB first, using a single full-adder cell and a carry flip-flop.
- Used where area matters more than latency.
- Start/busy/done handshake; sits between operand registers and downstream accumulate/compare logic.

Parameters:
WIDTH, 4, operand and sum width in bits (legal range 2..32)

Ports:
clk    input   1      rising-edge clock
rst    input   1      synchronous, active-high reset
start  input   1      request; sampled only when not busy
A      input   WIDTH  addend, captured on accepted start
B      input   WIDTH  addend, captured on accepted start
Cin    input   1      carry-in, captured on accepted start
busy   output  1      high while a computation is in progress
done   output  1      one-cycle pulse when S/Co become valid
S      output  WIDTH  sum, valid from done, held until next accepted start
Co     output  1      carry-out of MSB, same validity as S

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE.
  - busy=0, done=0, S=0, Co=0.
  - Internal shift registers, carry flop and bit counter cleared.
  - Applies from any state, including mid-RUN; the in-flight operation is discarded with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge -> capture A, B into shift regs, Cin into carry flop; counter=0; go RUN.
  - Otherwise stay in IDLE.
- RUN: each edge:
  - sum_bit = a[0]^b[0]^c.
  - c <= a[0]&b[0] | a[0]&c | b[0]&c.
  - sum_bit shifted into S accumulator from the MSB side.
  - A/B shift regs shift right; counter increments.
  - When counter reaches WIDTH-1 on this edge: go DONE; final carry written to Co and final sum to S.
- DONE: done=1 for exactly one cycle, busy=0.
  - start=1 in DONE is accepted (back-to-back): behaves as IDLE acceptance, next state RUN.
  - Otherwise next state is IDLE.
- busy=1 exactly in RUN (WIDTH cycles).
- Latency:
  - start accepted at edge k.
  - done high during the cycle following edge k+WIDTH.
  - Throughput: one add per WIDTH+1 cycles.
- start while busy is ignored: no capture, no effect on the in-flight result.
- A/B/Cin changes after capture have no effect.
- S/Co visible outputs update only at the RUN->DONE edge.
  - The shift accumulator is internal; S is not observed mid-RUN.
  - S/Co otherwise hold their last result through IDLE and into the next RUN until the next RUN->DONE edge.
- Arithmetic: unsigned modulo 2^WIDTH; Co is the true (WIDTH+1)th sum bit.
- Counter width: clog2(WIDTH); no wrap beyond WIDTH-1.

Optional Feature:
SERIAL_ADDER_OVF_EN
- Defined:
  - Extra output port Ovf (output, 1 bit) is present.
  - Ovf = two's-complement overflow = carry into MSB XOR carry out of MSB.
  - Updated at the same edge as S/Co; reset value 0; held with S.
- Undefined:
  - Port Ovf does not exist.
  - No extra flops (the carry-into-MSB register is removed).

Test Plan:
1. WIDTH=4, reset, then start with A=5, B=3, Cin=0 -> busy high 4 cycles; done pulse 5 cycles after start edge; S=8, Co=0 (Ovf=1 if enabled).
2. A=15, B=1, Cin=0 -> S=0, Co=1 (Ovf=0); then A=15, B=15, Cin=1 -> S=15, Co=1.
3. A=7, B=1, Cin=0 with SERIAL_ADDER_OVF_EN -> S=8, Co=0, Ovf=1; A=8, B=8 -> S=0, Co=1, Ovf=1.
4. start with A=2, B=2, then pulse start with A=9, B=9 while busy -> ignored; result S=4, Co=0; single done pulse.
5. start held high continuously, operands fixed at A=6, B=6 -> back-to-back results S=12, done pulses every 5 cycles, no idle gap.
6. rst asserted two cycles into RUN -> next cycle busy=0, done=0, S=0, Co=0; no done pulse follows; new start afterward computes correctly (A=3, B=4 -> S=7).
